// File: rtl/lab7soc_pio_blink_if.sv
// Avalon-MM slave bus bundle for the blinking output PIO.
interface lab7soc_pio_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lab7soc_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear writes and a per-bit blink mask
// gated by a programmable half-period prescaler.
module lab7soc_pio_blink #(
    parameter int unsigned DATA_WIDTH   = 14,
    parameter int unsigned CNT_WIDTH    = 26,
    parameter int unsigned RESET_VALUE  = 0,
    parameter int unsigned PERIOD_RESET = 24999999
) (
    input  logic                      clk,
    input  logic                      reset_n,
    lab7soc_pio_blink_if.slave        bus,
    output logic [DATA_WIDTH-1:0]     out_port
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_MASK     = 3'd1,
        REG_PERIOD   = 3'd2,
        REG_STATUS   = 3'd3,
        REG_OUTSET   = 3'd4,
        REG_OUTCLEAR = 3'd5
    } reg_addr_e;

    logic                  wr;
    logic                  wr_data;
    logic                  wr_mask;
    logic                  wr_period;
    logic                  wr_set;
    logic                  wr_clr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [CNT_WIDTH-1:0]  wperiod;

    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] mask;
    logic [CNT_WIDTH-1:0]  period;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  phase;
    logic                  running;

    // Write data bits above the register widths are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.writedata};

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wdata   = bus.writedata[DATA_WIDTH-1:0];
    assign wperiod = bus.writedata[CNT_WIDTH-1:0];
    assign running = |mask;

    // Decode the write strobe into per-register enables.
    always_comb begin
        wr_data   = 1'b0;
        wr_mask   = 1'b0;
        wr_period = 1'b0;
        wr_set    = 1'b0;
        wr_clr    = 1'b0;
        if (wr) begin
            case (bus.address)
                REG_DATA:     wr_data   = 1'b1;
                REG_MASK:     wr_mask   = 1'b1;
                REG_PERIOD:   wr_period = 1'b1;
                REG_OUTSET:   wr_set    = 1'b1;
                REG_OUTCLEAR: wr_clr    = 1'b1;
                default:      ;
            endcase
        end
    end

    // Output data register: plain, set and clear writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= DATA_WIDTH'(RESET_VALUE);
        end else if (wr_data) begin
            data_out <= wdata;
        end else if (wr_set) begin
            data_out <= data_out | wdata;
        end else if (wr_clr) begin
            data_out <= data_out & ~wdata;
        end
    end

    // Blink mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= wdata;
        end
    end

    // Prescaler: a period write restarts the phase; an idle mask parks it at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= CNT_WIDTH'(PERIOD_RESET);
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (wr_period) begin
            period <= wperiod;
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (!running) begin
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (cnt == period) begin
            cnt    <= '0;
            phase  <= ~phase;
        end else begin
            cnt    <= cnt + CNT_WIDTH'(1);
        end
    end

    // Zero-latency read mux, zero-extended to the bus width.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            REG_DATA:   bus.readdata = 32'(data_out);
            REG_MASK:   bus.readdata = 32'(mask);
            REG_PERIOD: bus.readdata = 32'(period);
            REG_STATUS: bus.readdata = {30'b0, running, phase};
            default:    ;
        endcase
    end

    assign out_port = data_out & ~(mask & {DATA_WIDTH{phase}});

endmodule

// File: tb/tb_lab7soc_pio_blink.sv
// Self-checking bench: randomized bus traffic against an arithmetic model of
// the PIO, plus directed literal checks; a second 8-bit instance shares the bus.
module tb_lab7soc_pio_blink;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    lab7soc_pio_blink_if bus ();
    lab7soc_pio_blink_if bus8 ();

    assign bus8.address    = bus.address;
    assign bus8.chipselect = bus.chipselect;
    assign bus8.write_n    = bus.write_n;
    assign bus8.writedata  = bus.writedata;

    logic [13:0] out_port;
    logic [7:0]  out8;

    lab7soc_pio_blink #(
        .DATA_WIDTH  (14),
        .CNT_WIDTH   (26),
        .RESET_VALUE (0),
        .PERIOD_RESET(24999999)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .out_port(out_port)
    );

    lab7soc_pio_blink #(
        .DATA_WIDTH  (8),
        .CNT_WIDTH   (26),
        .RESET_VALUE (0),
        .PERIOD_RESET(24999999)
    ) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave),
        .out_port(out8)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: phase derived from the number of running edges since
    // the last restart, rather than from a counter/toggle pair.
    logic [13:0]     m_data;
    logic [13:0]     m_mask;
    logic [25:0]     m_period;
    longint unsigned m_run;

    function automatic logic m_phase();
        longint unsigned hp;
        hp = 64'(m_period) + 64'd1;
        return ((m_run / hp) % 64'd2) != 64'd0;
    endfunction

    function automatic logic [13:0] m_out();
        return m_data & ~(m_mask & {14{m_phase()}});
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return 32'(m_mask);
            3'd2:    return 32'(m_period);
            3'd3:    return {30'b0, (m_mask != 14'd0), m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    // Model state update on each edge from the pre-edge bus and state.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   <= '0;
            m_mask   <= '0;
            m_period <= 26'd24999999;
            m_run    <= 0;
        end else begin
            if (bus.chipselect && !bus.write_n && bus.address == 3'd2) begin
                m_run    <= 0;
                m_period <= bus.writedata[25:0];
            end else if (m_mask == 14'd0) begin
                m_run <= 0;
            end else begin
                m_run <= m_run + 1;
            end
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_data <= bus.writedata[13:0];
                    3'd1: m_mask <= bus.writedata[13:0];
                    3'd4: m_data <= m_data | bus.writedata[13:0];
                    3'd5: m_data <= m_data & ~bus.writedata[13:0];
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle compare of the main instance against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en && reset_n) begin
            chk("model_out_port", 32'(out_port), 32'(m_out()));
            chk("model_readdata", bus.readdata, m_rd(bus.address));
        end
    end

    task automatic cyc(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = d;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b1, 1'b1, a, 32'd0);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset state readback
        for (int unsigned a = 0; a < 8; a++) begin
            rd(3'(a));
            chk("reset_readdata", bus.readdata, (a == 2) ? 32'd24999999 : 32'd0);
        end
        chk("reset_out_port", 32'(out_port), 32'd0);
        chk("reset_out8", 32'(out8), 32'd0);

        // Plain write, atomic clear, atomic set
        wr(3'd0, 32'h0000_3FFF);
        #1 chk("data_before_edge", 32'(out_port), 32'h0);
        rd(3'd0);
        chk("data_rd", bus.readdata, 32'h3FFF);
        chk("data_out", 32'(out_port), 32'h3FFF);
        wr(3'd5, 32'h0000_00F0);
        #1 chk("clr_before_edge", 32'(out_port), 32'h3FFF);
        rd(3'd0);
        chk("clr_rd", bus.readdata, 32'h3F0F);
        chk("clr_out", 32'(out_port), 32'h3F0F);
        wr(3'd4, 32'h0000_0005);
        rd(3'd0);
        chk("set_rd", bus.readdata, 32'h3F0F);
        rd(3'd4);
        chk("outset_rd", bus.readdata, 32'h0);

        // Blink bit0 with half period 3: 4 cycles high, then 4 low
        wr(3'd2, 32'd3);
        wr(3'd0, 32'd3);
        wr(3'd1, 32'd1);
        for (int unsigned i = 0; i < 6; i++) begin
            rd(3'd3);
            chk("blink_out", 32'(out_port), (i < 4) ? 32'd3 : 32'd2);
            chk("blink_status", bus.readdata, (i < 4) ? 32'd2 : 32'd3);
        end
        // Mask cleared while phase = 1
        wr(3'd1, 32'd0);
        #1 chk("unmask_before_edge", 32'(out_port), 32'd2);
        rd(3'd3);
        chk("unmask_out", 32'(out_port), 32'd3);
        rd(3'd3);
        chk("unmask_status", bus.readdata, 32'd0);
        chk("unmask_out2", 32'(out_port), 32'd3);

        // Period rewrite while phase = 1 restarts at phase 0, 2 high / 2 low
        wr(3'd1, 32'd1);
        repeat (5) cyc(1'b0, 1'b1, 3'd0, 32'd0);
        wr(3'd2, 32'd1);
        #1 chk("pre_rewrite_out", 32'(out_port), 32'd2);
        for (int unsigned j = 0; j < 6; j++) begin
            rd(3'd3);
            chk("rewrite_out", 32'(out_port), (((j / 2) % 2) != 0) ? 32'd2 : 32'd3);
        end
        wr(3'd1, 32'd0);

        // Upper write-data bits discarded on both widths
        wr(3'd0, 32'hFFFF_FF5A);
        rd(3'd0);
        chk("wide_rd8", bus8.readdata, 32'h0000_005A);
        chk("wide_out8", 32'(out8), 32'h5A);
        chk("wide_rd14", bus.readdata, 32'h0000_3F5A);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_out8", 32'(out8), 32'h0);
        chk("async_out14", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd2);
        chk("async_period", bus.readdata, 32'd24999999);

        // Randomized traffic checked by the model
        for (int unsigned k = 0; k < 3000; k++) begin
            logic        cs;
            logic        wn;
            logic [2:0]  a;
            logic [31:0] d;
            cs = ($urandom_range(0, 3) != 0);
            wn = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd2) d = (d & 32'hFC00_0000) | 32'($urandom_range(0, 5));
            if (a == 3'd1 && $urandom_range(0, 3) == 0) d = 32'd0;
            cyc(cs, wn, a, d);
        end
        cyc(1'b0, 1'b1, 3'd0, 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
